// File: rtl/forward_hazard_unit_if.sv
// Stage-2 decode inputs, EX zero flag, and the forwarding/hazard outputs
// exchanged between the pipeline datapath and forward_hazard_unit.
interface forward_hazard_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       rs1_2;
    logic [4:0]       rs2_2;
    logic [4:0]       rd_2;
    logic             RegWrite_2;
    logic             MemRead_2;
    logic             Branch_2;
    logic             use_imm_2;
    logic             zero;
    logic [1:0]       Sel_A;
    logic [1:0]       Sel_B;
    logic             Stall_2;
    logic             Flush_3;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs1_2, rs2_2, rd_2, RegWrite_2, MemRead_2, Branch_2, use_imm_2, zero,
        input  Sel_A, Sel_B, Stall_2, Flush_3, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_2, rs2_2, rd_2, RegWrite_2, MemRead_2, Branch_2, use_imm_2, zero,
        output Sel_A, Sel_B, Stall_2, Flush_3, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/forward_hazard_unit.sv
// Operand-forwarding select, load-use stall and taken-branch flush for the
// 5-stage pipeline, with saturating stall/flush event counters.
module forward_hazard_unit #(
    parameter int unsigned CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    forward_hazard_unit_if.slave hz_if
);
    localparam int unsigned REG_W = 5;
    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(3);

    // Only EX and MEM producers feed the forward muxes; WB contents are never consulted.
    logic [REG_W-1:0] rd_3_q, rd_3_d;
    logic             regwrite_3_q, regwrite_3_d;
    logic             memread_3_q, memread_3_d;
    logic             branch_3_q, branch_3_d;
    logic [REG_W-1:0] rd_4_q, rd_4_d;
    logic             regwrite_4_q, regwrite_4_d;
    logic [SEL_W-1:0] sel_a_q, sel_a_d;
    logic [SEL_W-1:0] sel_b_q, sel_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic flush_c;
    logic load_use_c;
    logic stall_c;
    logic bubble_c;

    // Newest producer first: EX now means MEM next cycle, MEM now means WB next cycle.
    function automatic logic [SEL_W-1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic             rw3,
        input logic [REG_W-1:0] rd3,
        input logic             rw4,
        input logic [REG_W-1:0] rd4
    );
        logic [SEL_W-1:0] sel;
        sel = SEL_RF;
        if (rs == '0)                 sel = SEL_RF;
        else if (rw3 && (rd3 == rs))  sel = SEL_MEM;
        else if (rw4 && (rd4 == rs))  sel = SEL_WB;
        return sel;
    endfunction

    // Hazard and flush decode; flush wins since the stalled instruction is wrong-path.
    always_comb begin
        flush_c    = branch_3_q & hz_if.zero;
        load_use_c = memread_3_q && (rd_3_q != '0) &&
                     ((rd_3_q == hz_if.rs1_2) || ((rd_3_q == hz_if.rs2_2) && !hz_if.use_imm_2));
        stall_c    = load_use_c & ~flush_c;
        bubble_c   = stall_c | flush_c;
    end

    always_comb begin
        rd_3_d       = hz_if.rd_2;
        regwrite_3_d = hz_if.RegWrite_2;
        memread_3_d  = hz_if.MemRead_2;
        branch_3_d   = hz_if.Branch_2;
        sel_a_d      = fwd_sel(hz_if.rs1_2, regwrite_3_q, rd_3_q, regwrite_4_q, rd_4_q);
        sel_b_d      = hz_if.use_imm_2 ? SEL_IMM
                     : fwd_sel(hz_if.rs2_2, regwrite_3_q, rd_3_q, regwrite_4_q, rd_4_q);
        rd_4_d       = rd_3_q;
        regwrite_4_d = regwrite_3_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;

        if (bubble_c) begin
            rd_3_d       = '0;
            regwrite_3_d = 1'b0;
            memread_3_d  = 1'b0;
            branch_3_d   = 1'b0;
            sel_a_d      = SEL_RF;
            sel_b_d      = SEL_RF;
        end

        if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_c && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_3_q       <= '0;
            regwrite_3_q <= 1'b0;
            memread_3_q  <= 1'b0;
            branch_3_q   <= 1'b0;
            rd_4_q       <= '0;
            regwrite_4_q <= 1'b0;
            sel_a_q      <= SEL_RF;
            sel_b_q      <= SEL_RF;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            rd_3_q       <= rd_3_d;
            regwrite_3_q <= regwrite_3_d;
            memread_3_q  <= memread_3_d;
            branch_3_q   <= branch_3_d;
            rd_4_q       <= rd_4_d;
            regwrite_4_q <= regwrite_4_d;
            sel_a_q      <= sel_a_d;
            sel_b_q      <= sel_b_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign hz_if.Sel_A     = sel_a_q;
    assign hz_if.Sel_B     = sel_b_q;
    assign hz_if.Stall_2   = stall_c;
    assign hz_if.Flush_3   = flush_c;
    assign hz_if.stall_cnt = stall_cnt_q;
    assign hz_if.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed pipeline scenarios plus randomized traffic, checked every cycle
// against an age-ordered in-flight instruction model.
module tb_forward_hazard_unit;
    logic clk;
    logic rst_n;

    forward_hazard_unit_if #(.CNT_W(16)) bus ();
    forward_hazard_unit_if #(.CNT_W(2))  bus_s ();

    forward_hazard_unit #(.CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .hz_if(bus));
    forward_hazard_unit #(.CNT_W(2))  u_sat (.clk(clk), .rst_n(rst_n), .hz_if(bus_s));

    assign bus_s.rs1_2      = bus.rs1_2;
    assign bus_s.rs2_2      = bus.rs2_2;
    assign bus_s.rd_2       = bus.rd_2;
    assign bus_s.RegWrite_2 = bus.RegWrite_2;
    assign bus_s.MemRead_2  = bus.MemRead_2;
    assign bus_s.Branch_2   = bus.Branch_2;
    assign bus_s.use_imm_2  = bus.use_imm_2;
    assign bus_s.zero       = bus.zero;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: instructions in flight ordered by age (0 = in EX, 1 = in MEM).
    typedef struct packed {
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       br;
    } instr_t;

    instr_t     inflight[2];
    logic [1:0] m_sel_a, m_sel_b;
    int         m_stalls, m_flushes;

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        for (int age = 0; age < 2; age++)
            if (inflight[age].rw && inflight[age].rd == rs)
                return (age == 0) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    function automatic logic m_flush();
        return inflight[0].br && bus.zero;
    endfunction

    function automatic logic m_stall();
        logic dep;
        dep = inflight[0].mr && inflight[0].rd != 5'd0 &&
              (inflight[0].rd == bus.rs1_2 || (inflight[0].rd == bus.rs2_2 && !bus.use_imm_2));
        return dep && !m_flush();
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight[0] = '0;
            inflight[1] = '0;
            m_sel_a = 2'b00;
            m_sel_b = 2'b00;
            m_stalls = 0;
            m_flushes = 0;
        end else begin
            logic s, f;
            s = m_stall();
            f = m_flush();
            if (s) m_stalls++;
            if (f) m_flushes++;
            m_sel_a = m_fwd(bus.rs1_2);
            m_sel_b = bus.use_imm_2 ? 2'b11 : m_fwd(bus.rs2_2);
            inflight[1] = inflight[0];
            if (s || f) begin
                inflight[0] = '0;
                m_sel_a = 2'b00;
                m_sel_b = 2'b00;
            end else begin
                inflight[0] = '{rd: bus.rd_2, rw: bus.RegWrite_2, mr: bus.MemRead_2, br: bus.Branch_2};
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model Sel_A", 32'(bus.Sel_A), 32'(m_sel_a));
        chk("model Sel_B", 32'(bus.Sel_B), 32'(m_sel_b));
        chk("model Stall_2", 32'(bus.Stall_2), 32'(m_stall()));
        chk("model Flush_3", 32'(bus.Flush_3), 32'(m_flush()));
        chk("model stall_cnt", 32'(bus.stall_cnt), 32'(sat(m_stalls, 65535)));
        chk("model flush_cnt", 32'(bus.flush_cnt), 32'(sat(m_flushes, 65535)));
        chk("model sat stall_cnt", 32'(bus_s.stall_cnt), 32'(sat(m_stalls, 3)));
        chk("model sat flush_cnt", 32'(bus_s.flush_cnt), 32'(sat(m_flushes, 3)));
    end

    task automatic put(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic br,
                       input logic imm, input logic z);
        bus.rs1_2      = rs1;
        bus.rs2_2      = rs2;
        bus.rd_2       = rd;
        bus.RegWrite_2 = rw;
        bus.MemRead_2  = mr;
        bus.Branch_2   = br;
        bus.use_imm_2  = imm;
        bus.zero       = z;
    endtask

    task automatic nop(input logic z);
        put(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, z);
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        nop(1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state, then add x5 followed directly by sub x6,x5,x5.
        put(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        mid();
        chk("reset Sel_A", 32'(bus.Sel_A), 32'd0);
        chk("reset Sel_B", 32'(bus.Sel_B), 32'd0);
        chk("reset Stall_2", 32'(bus.Stall_2), 32'd0);
        chk("reset stall_cnt", 32'(bus.stall_cnt), 32'd0);
        nxt();
        put(5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        mid();
        chk("ex-ex no stall", 32'(bus.Stall_2), 32'd0);
        nxt();
        nop(1'b0);
        mid();
        chk("ex-ex Sel_A", 32'(bus.Sel_A), 32'd1);
        chk("ex-ex Sel_B", 32'(bus.Sel_B), 32'd1);
        nxt();

        // add x9, filler, sub x6,x9,x9.
        put(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        nxt();
        nop(1'b0);
        nxt();
        put(5'd9, 5'd9, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        nxt();
        put(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        mid();
        chk("mem-ex Sel_A", 32'(bus.Sel_A), 32'd2);
        chk("mem-ex Sel_B", 32'(bus.Sel_B), 32'd2);
        nxt();

        // Write to x0, then addi x3,x0,imm.
        put(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        nxt();
        put(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        mid();
        chk("x0 Sel_A", 32'(bus.Sel_A), 32'd0);
        chk("imm Sel_B", 32'(bus.Sel_B), 32'd3);
        nxt();

        // lw x7 (presented above), then add x8,x7,x2.
        put(5'd7, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        mid();
        chk("load-use Stall_2", 32'(bus.Stall_2), 32'd1);
        chk("load-use cnt before", 32'(bus.stall_cnt), 32'd0);
        nxt();
        mid();
        chk("load-use stall released", 32'(bus.Stall_2), 32'd0);
        chk("load-use cnt after", 32'(bus.stall_cnt), 32'd1);
        chk("load-use bubble Sel_A", 32'(bus.Sel_A), 32'd0);
        nxt();
        put(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        mid();
        chk("load-use Sel_A", 32'(bus.Sel_A), 32'd2);
        chk("load-use Sel_B", 32'(bus.Sel_B), 32'd0);
        nxt();

        // beq in EX with zero=1, then a beq with zero=0.
        put(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        mid();
        chk("taken Flush_3", 32'(bus.Flush_3), 32'd1);
        chk("taken flush_cnt before", 32'(bus.flush_cnt), 32'd0);
        nxt();
        put(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        mid();
        chk("flushed bubble Sel_A", 32'(bus.Sel_A), 32'd0);
        chk("taken flush_cnt after", 32'(bus.flush_cnt), 32'd1);
        nxt();
        put(5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        mid();
        chk("not-taken Flush_3", 32'(bus.Flush_3), 32'd0);
        nxt();

        // Flush over a simultaneous load-use condition.
        put(5'd10, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        mid();
        chk("flush>stall Flush_3", 32'(bus.Flush_3), 32'd1);
        chk("flush>stall Stall_2", 32'(bus.Stall_2), 32'd0);
        nxt();
        nop(1'b0);
        mid();
        chk("flush>stall stall_cnt", 32'(bus.stall_cnt), 32'd1);
        chk("flush>stall flush_cnt", 32'(bus.flush_cnt), 32'd2);
        nxt();

        // Reset asserted in the middle of a stall.
        put(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        nxt();
        put(5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        mid();
        chk("pre-reset Stall_2", 32'(bus.Stall_2), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset Stall_2", 32'(bus.Stall_2), 32'd0);
        chk("async reset Flush_3", 32'(bus.Flush_3), 32'd0);
        chk("async reset Sel_A", 32'(bus.Sel_A), 32'd0);
        chk("async reset Sel_B", 32'(bus.Sel_B), 32'd0);
        chk("async reset stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("async reset flush_cnt", 32'(bus.flush_cnt), 32'd0);
        nxt();
        rst_n = 1'b1;
        mid();
        chk("no residual stall", 32'(bus.Stall_2), 32'd0);
        nxt();

        // Randomized traffic over a small register window to provoke hazards.
        for (int i = 0; i < 4000; i++) begin
            put(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 1)));
            nxt();
        end

        mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
